// File: rtl/dot_product_acc_pkg.sv
// Shared types and helpers for the dot-product accumulator.
package dot_product_acc_pkg;

  // Controller states: gathering products, or presenting a finished sum.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Accumulator width: a full product plus enough guard bits for terms adds.
  function automatic int calc_aw(input int n, input int terms);
    return 2 * n + $clog2(terms);
  endfunction

endpackage

// File: rtl/acc_extend.sv
// Widens a 2*n-bit product to the accumulator width, signed or unsigned.
module acc_extend #(
  parameter int n  = 8,
  parameter int aw = 18
) (
  input  logic [2*n-1:0] din,
  input  logic           mode,
  output logic [aw-1:0]  dout
);

  // Replicate the product MSB when mode is signed, zero-fill otherwise.
  always_comb begin
    if (mode) dout = {{(aw - 2*n){din[2*n-1]}}, din};
    else      dout = {{(aw - 2*n){1'b0}}, din};
  end

endmodule

// File: rtl/dot_product_acc.sv
// Sums groups of `terms` products and hands each sum downstream with a
// valid/ready handshake. The signedness of a group is fixed by its first term.
module dot_product_acc
  import dot_product_acc_pkg::*;
#(
  parameter int  n     = 8,
  parameter int  terms = 4,
  localparam int aw    = calc_aw(n, terms)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [2*n-1:0] up_data,
  input  logic          up_signed,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [aw-1:0] down_data,
  output logic          down_signed
);

  localparam int cnt_w = $clog2(terms) + 1;

  state_t             state, state_next;
  logic [cnt_w-1:0]   count;
  logic [aw-1:0]      acc;
  logic               mode;

  logic               up_fire;
  logic               down_fire;
  logic               first_term;
  logic               last_term;
  logic               term_mode;
  logic [aw-1:0]      term_ext;
  logic [aw-1:0]      sum;

  assign up_fire    = up_valid & up_ready;
  assign down_fire  = down_valid & down_ready;
  assign first_term = (count == '0);
  assign last_term  = (count == cnt_w'(terms - 1));

  // The first term of a group supplies its own mode; later terms follow the latch.
  assign term_mode = first_term ? up_signed : mode;
  assign sum       = first_term ? term_ext : acc + term_ext;

  acc_extend #(
    .n  (n),
    .aw (aw)
  ) u_extend (
    .din  (up_data),
    .mode (term_mode),
    .dout (term_ext)
  );

  // Next-state and handshake outputs; up_ready depends only on state and rst.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    case (state)
      ST_ACC: begin
        up_ready = ~rst;
        if (up_valid && !rst && last_term) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        down_valid = 1'b1;
        if (down_ready) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  // Accumulator, term counter, group mode and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      acc         <= '0;
      mode        <= 1'b0;
      down_data   <= '0;
      down_signed <= 1'b0;
    end else begin
      if (up_fire) begin
        acc   <= sum;
        count <= count + cnt_w'(1);
        if (first_term) mode <= up_signed;
        if (last_term) begin
          down_data   <= sum;
          down_signed <= term_mode;
        end
      end
      if (down_fire) count <= '0;
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: the driver pushes expected group sums
// into a queue, and a monitor pops and compares on each downstream handshake.
module tb_dot_product_acc;

  localparam int n     = 8;
  localparam int terms = 4;
  localparam int aw    = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [2*n-1:0] up_data;
  logic          up_signed;
  logic          down_valid;
  logic          down_ready;
  logic [aw-1:0] down_data;
  logic          down_signed;

  typedef struct {
    logic [aw-1:0] data;
    logic          sgn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  dot_product_acc #(
    .n     (n),
    .terms (terms)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_data     (up_data),
    .up_signed   (up_signed),
    .down_valid  (down_valid),
    .down_ready  (down_ready),
    .down_data   (down_data),
    .down_signed (down_signed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [aw-1:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sgn  = s;
    exp_q.push_back(e);
  endtask

  // Present one product, hold it until accepted, then drop valid after the edge.
  task automatic send_term(input logic [2*n-1:0] d, input logic s);
    int waited = 0;
    up_valid  = 1'b1;
    up_data   = d;
    up_signed = s;
    @(negedge clk);
    while (!up_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!up_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got up_ready=0, expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  // Wait, bounded, for every expected result to be consumed.
  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: no upstream acceptance while a result is held; score each result.
  always @(negedge clk) begin
    if (!rst && down_valid) check("no_accept_in_hold", 32'(up_ready), 32'd0);
    if (!rst && down_valid && down_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%0h, expected none", down_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_data", 32'(down_data), 32'(mon_e.data));
        check("result_signed", 32'(down_signed), 32'(mon_e.sgn));
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    logic [2*n-1:0] v;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_signed  = 1'b0;
    down_ready = 1'b1;

    // Reset behaviour.
    @(negedge clk);
    check("up_ready_in_rst", 32'(up_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("up_ready_after_rst", 32'(up_ready), 32'd1);
    check("down_valid_after_rst", 32'(down_valid), 32'd0);
    check("down_data_after_rst", 32'(down_data), 32'd0);
    check("down_signed_after_rst", 32'(down_signed), 32'd0);
    @(posedge clk);
    #1;

    // Four unsigned 0xFFFF; result one cycle after the last transfer.
    push_exp(18'h3FFFC, 1'b0);
    for (int i = 0; i < 3; i++) send_term(16'hFFFF, 1'b0);
    check("latency_before_last", 32'(down_valid), 32'd0);
    send_term(16'hFFFF, 1'b0);
    check("latency_after_last", 32'(down_valid), 32'd1);

    // Four signed 0xC080 (-16256) -> -65024.
    push_exp(18'h30200, 1'b1);
    for (int i = 0; i < 4; i++) send_term(16'hC080, 1'b1);

    // Mode latched from the first term only.
    push_exp(18'h00002, 1'b1);
    send_term(16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) send_term(16'h0001, 1'b0);

    // Backpressure: result held stable for 5 cycles.
    wait_drain();
    down_ready = 1'b0;
    push_exp(18'h00064, 1'b0);
    send_term(16'd10, 1'b0);
    send_term(16'd20, 1'b0);
    send_term(16'd30, 1'b0);
    send_term(16'd40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(down_valid), 32'd1);
      check("hold_data", 32'(down_data), 32'h64);
      check("hold_up_ready", 32'(up_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    check("up_ready_after_handshake", 32'(up_ready), 32'd1);
    push_exp(18'h00004, 1'b0);
    for (int i = 0; i < 4; i++) send_term(16'h0001, 1'b0);

    // Reset mid-group discards the partial sum.
    wait_drain();
    push_exp(18'h0000A, 1'b0);
    send_term(16'd7, 1'b0);
    send_term(16'd9, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("up_ready_mid_rst", 32'(up_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("valid_after_mid_rst", 32'(down_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      v = 16'(i);
      send_term(v, 1'b0);
    end

    // Random idle gaps between terms do not change the sum.
    wait_drain();
    push_exp(18'h0001A, 1'b0);
    for (int i = 5; i <= 8; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      v = 16'(i);
      send_term(v, 1'b0);
    end

    // Reset while holding a result drops it.
    wait_drain();
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_term(16'h0003, 1'b0);
    check("hold_before_rst", 32'(down_valid), 32'd1);
    check("hold_data_before_rst", 32'(down_data), 32'h0000C);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("valid_after_hold_rst", 32'(down_valid), 32'd0);
    check("data_after_hold_rst", 32'(down_data), 32'd0);
    down_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end

    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_product_acc.md
DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

Interface
REQ-001 Parameter n, default 8: operand width of the upstream multiplier; products are 2*n bits.
REQ-002 Parameter terms, default 4: number of products summed per result; legal range 2..256.
REQ-003 Derived constant aw = 2*n + $clog2(terms): accumulator and result width (18 at defaults).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 up_valid  input  1  upstream product valid.
REQ-007 up_ready  output  1  block accepts a product this cycle.
REQ-008 up_data  input  2*n  product word from the multiplier stage.
REQ-009 up_signed  input  1  1 = up_data is two's complement; 0 = unsigned.
REQ-010 down_valid  output  1  result valid.
REQ-011 down_ready  input  1  downstream accepts the result.
REQ-012 down_data  output  aw  accumulated sum of one group of terms.
REQ-013 down_signed  output  1  interpretation of down_data: the group's latched mode.

Function
REQ-014 A transfer occurs on each edge where valid and ready are both 1; there is no other transfer.
REQ-015 Two states: ST_ACC, where up_ready=1 and down_valid=0, and ST_HOLD, where up_ready=0 and down_valid=1.
REQ-016 In ST_ACC, each accepted product is extended to aw bits: sign-extended if the group mode is 1, zero-extended if it is 0.
REQ-017 The first accepted term of a group (count==0) loads acc with the extended value, latches up_signed as the group mode, and sets count=1.
REQ-018 Later terms set acc to acc plus the extended value modulo 2^aw, ignore up_signed, and increment count.
REQ-019 Acceptance of term number terms (count==terms-1) moves the block to ST_HOLD and loads down_data and down_signed; down_valid is 1 in the next cycle.
REQ-020 Latency from the last upstream transfer to down_valid=1 is 1 cycle.
REQ-021 While down_valid=1 and down_ready=0, down_data and down_signed hold stable and up_ready stays 0.
REQ-022 A downstream transfer returns the block to ST_ACC with count=0, so up_ready=1 on the next cycle; throughput is terms+1 cycles per group at most.
REQ-023 up_valid=0 cycles in ST_ACC change no state; gaps between terms do not affect the result.
REQ-024 The sum cannot overflow aw bits in either mode, so no saturation or overflow flag exists.
REQ-025 down_data keeps its last value after the downstream handshake until the next load.

Reset
REQ-026 When rst is 1 at an edge, the block sets: state ST_ACC, count 0, acc 0, down_valid 0, down_data 0, down_signed 0, group mode 0.
REQ-027 up_ready is 0 in any cycle where rst=1 and 1 in the first cycle after rst is released.
REQ-028 Reset in the middle of a group discards the partial sum; no result is emitted for that group.
REQ-029 Reset while in ST_HOLD drops the pending result.

Structure
REQ-030 Shared package dot_product_acc_pkg holds state_t {ST_ACC, ST_HOLD} and a function that computes aw from n and terms.
REQ-031 One sub-module, acc_extend: parameterized combinational sign/zero extender from 2*n to aw bits, selected by the mode bit.
REQ-032 count width is $clog2(terms)+1; there are no latches and no combinational path from up_valid to up_ready.

Verification (n=8, terms=4, aw=18)
REQ-033 Four unsigned 0xFFFF with down_ready=1 -> down_data=0x3FFFC, down_signed=0, down_valid exactly 1 cycle after the 4th transfer.
REQ-034 Four signed 0xC080 (-16256) -> down_data=0x30200 (-65024), down_signed=1.
REQ-035 First term 0xFFFF with up_signed=1, then three 0x0001 with up_signed=0 -> down_data=0x00002, down_signed=1.
REQ-036 down_ready held 0 for 5 cycles after down_valid -> down_data stable and up_ready=0 throughout; after the handshake, up_ready=1 on the next cycle and the next group (1,1,1,1 unsigned) gives 0x00004.
REQ-037 Two terms accepted, then rst for 1 cycle, then unsigned 1,2,3,4 -> exactly one result, 0x0000A.
REQ-038 Unsigned terms 5,6,7,8 with random up_valid gaps of 0-3 cycles -> down_data=0x0001A, and no transfer occurs in ST_HOLD.
